// File: rtl/riscv_task3_if.sv
// Control/observation bundle for the riscv_task3 pipeline: the stall request
// goes in, and every stage's visible control and datapath values come out.
interface riscv_task3_if;
  logic        stall;
  logic        branch, memread, memtoreg, memwrite, regwrite, ALUsrc;
  logic [1:0]  ALUop;
  logic        Branch, Memread, Memtoreg, Memwrite, Regwrite, Alusrc;
  logic [1:0]  aluop;
  logic [63:0] pc_out, pc_in, adderout1, adderout2;
  logic [31:0] instruction, inst_ifid_out;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm_data, readdata1, readdata2;
  logic [4:0]  RS1, RS2, RD;
  logic [3:0]  funct4_out;
  logic [1:0]  forwardA, forwardB;
  logic [63:0] a1, M1, M2, random, d, write_data;
  logic        BLT_Flag, regwrite_memwb_out;
  logic [63:0] r8, r19, r20, r21, r22;

  modport master (
    output stall,
    input  branch, memread, memtoreg, memwrite, regwrite, ALUsrc, ALUop,
    input  Branch, Memread, Memtoreg, Memwrite, Regwrite, Alusrc, aluop,
    input  pc_out, pc_in, adderout1, adderout2, instruction, inst_ifid_out,
    input  opcode, rd, rs1, rs2, funct3, funct7, imm_data, readdata1, readdata2,
    input  RS1, RS2, RD, funct4_out, forwardA, forwardB,
    input  a1, M1, M2, random, d, write_data, BLT_Flag, regwrite_memwb_out,
    input  r8, r19, r20, r21, r22
  );

  modport slave (
    input  stall,
    output branch, memread, memtoreg, memwrite, regwrite, ALUsrc, ALUop,
    output Branch, Memread, Memtoreg, Memwrite, Regwrite, Alusrc, aluop,
    output pc_out, pc_in, adderout1, adderout2, instruction, inst_ifid_out,
    output opcode, rd, rs1, rs2, funct3, funct7, imm_data, readdata1, readdata2,
    output RS1, RS2, RD, funct4_out, forwardA, forwardB,
    output a1, M1, M2, random, d, write_data, BLT_Flag, regwrite_memwb_out,
    output r8, r19, r20, r21, r22
  );
endinterface

// File: rtl/riscv_task3.sv
// Five-stage RV64I subset pipeline (add/sub/and/or/addi/ld/sd/beq/blt) with
// EX/MEM and MEM/WB forwarding, external stall, and branch resolution in MEM.
module riscv_task3 (
  input  logic         clk,
  input  logic         reset,
  riscv_task3_if.slave bus
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Program ROM, word-indexed; the fetch logic below picks bytes out of it.
  function automatic logic [31:0] rom_word(input logic [61:0] widx);
    logic [31:0] w;
    case (widx)
      62'd0:   w = 32'h00500993;  // addi x19,x0,5
      62'd1:   w = 32'h00300A13;  // addi x20,x0,3
      62'd2:   w = 32'h01498AB3;  // add  x21,x19,x20
      62'd3:   w = 32'h413A8B33;  // sub  x22,x21,x19
      62'd4:   w = 32'h01603023;  // sd   x22,0(x0)
      62'd5:   w = 32'h00003403;  // ld   x8,0(x0)
      62'd6:   w = 32'h013A4463;  // blt  x20,x19,+8
      62'd7:   w = 32'h06300413;  // addi x8,x0,99
      62'd8:   w = 32'h00000063;  // beq  x0,x0,0
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

  logic [63:0] pc_reg, pc_next, pc_plus4;
  logic [31:0] fetch_word;

  logic [31:0] ifid_inst_reg;
  logic [63:0] ifid_pc_reg;

  ctrl_t       id_ctrl;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_funct4;
  logic [63:0] id_imm, id_rd1, id_rd2;

  ctrl_t       idex_ctrl_reg;
  logic [63:0] idex_pc_reg, idex_rd1_reg, idex_rd2_reg, idex_imm_reg;
  logic [4:0]  idex_rs1_reg, idex_rs2_reg, idex_rd_reg;
  logic [3:0]  idex_funct4_reg;

  logic [1:0]  fwd_a, fwd_b;
  logic [63:0] ex_a, ex_rs2, ex_b, ex_result, ex_target;
  logic        ex_zero, ex_blt;

  logic        exmem_branch_reg, exmem_memtoreg_reg, exmem_memwrite_reg, exmem_regwrite_reg;
  logic        exmem_zero_reg, exmem_blt_reg;
  logic [2:0]  exmem_funct3_reg;
  logic [4:0]  exmem_rd_reg;
  logic [63:0] exmem_alu_reg, exmem_store_reg, exmem_target_reg;

  logic [5:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic        taken;

  logic        memwb_regwrite_reg, memwb_memtoreg_reg;
  logic [4:0]  memwb_rd_reg;
  logic [63:0] memwb_alu_reg, memwb_rdata_reg;
  logic [63:0] wb_data;

  logic [63:0] rf_reg   [32];
  logic [7:0]  dmem_reg [64];

  // ---------------- IF ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fetch
      logic [63:0] byte_addr;
      logic [31:0] word;
      assign byte_addr = pc_reg + 64'(gi);
      assign word      = rom_word(byte_addr[63:2]);
      assign fetch_word[gi*8 +: 8] = word[{byte_addr[1:0], 3'b000} +: 8];
    end
  endgenerate

  assign pc_plus4 = pc_reg + 64'd4;
  // A taken branch in MEM wins over stall; stall simply re-presents the same PC.
  assign pc_next  = taken ? exmem_target_reg : (bus.stall ? pc_reg : pc_plus4);

  // ---------------- ID ----------------
  assign id_opcode = ifid_inst_reg[6:0];
  assign id_rd     = ifid_inst_reg[11:7];
  assign id_funct3 = ifid_inst_reg[14:12];
  assign id_rs1    = ifid_inst_reg[19:15];
  assign id_rs2    = ifid_inst_reg[24:20];
  assign id_funct7 = ifid_inst_reg[31:25];
  // Only R-type uses funct7[5]; for addi that bit is part of the immediate.
  assign id_funct4 = {(id_opcode == OP_RTYPE) & id_funct7[5], id_funct3};

  always_comb begin
    id_ctrl = '0;
    case (id_opcode)
      OP_RTYPE:  begin id_ctrl.regwrite = 1'b1; id_ctrl.aluop = 2'b10; end
      OP_ITYPE:  begin id_ctrl.regwrite = 1'b1; id_ctrl.alusrc = 1'b1; id_ctrl.aluop = 2'b10; end
      OP_LOAD:   begin
        id_ctrl.memread  = 1'b1;
        id_ctrl.memtoreg = 1'b1;
        id_ctrl.regwrite = 1'b1;
        id_ctrl.alusrc   = 1'b1;
      end
      OP_STORE:  begin id_ctrl.memwrite = 1'b1; id_ctrl.alusrc = 1'b1; end
      OP_BRANCH: begin id_ctrl.branch = 1'b1; id_ctrl.aluop = 2'b01; end
      default:   id_ctrl = '0;
    endcase
  end

  always_comb begin
    id_imm = '0;
    case (id_opcode)
      OP_ITYPE, OP_LOAD: id_imm = {{52{ifid_inst_reg[31]}}, ifid_inst_reg[31:20]};
      OP_STORE:          id_imm = {{52{ifid_inst_reg[31]}}, ifid_inst_reg[31:25], ifid_inst_reg[11:7]};
      OP_BRANCH:         id_imm = {{52{ifid_inst_reg[31]}}, ifid_inst_reg[31], ifid_inst_reg[7],
                                   ifid_inst_reg[30:25], ifid_inst_reg[11:8]};
      default:           id_imm = '0;
    endcase
  end

  // Register reads see a write-back happening in the same cycle.
  always_comb begin
    id_rd1 = rf_reg[id_rs1];
    id_rd2 = rf_reg[id_rs2];
    if (id_rs1 == 5'd0)
      id_rd1 = '0;
    else if (memwb_regwrite_reg && memwb_rd_reg == id_rs1)
      id_rd1 = wb_data;
    if (id_rs2 == 5'd0)
      id_rd2 = '0;
    else if (memwb_regwrite_reg && memwb_rd_reg == id_rs2)
      id_rd2 = wb_data;
  end

  // ---------------- EX ----------------
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_regwrite_reg && exmem_rd_reg != 5'd0 && exmem_rd_reg == idex_rs1_reg)
      fwd_a = 2'b10;
    else if (memwb_regwrite_reg && memwb_rd_reg != 5'd0 && memwb_rd_reg == idex_rs1_reg)
      fwd_a = 2'b01;
    if (exmem_regwrite_reg && exmem_rd_reg != 5'd0 && exmem_rd_reg == idex_rs2_reg)
      fwd_b = 2'b10;
    else if (memwb_regwrite_reg && memwb_rd_reg != 5'd0 && memwb_rd_reg == idex_rs2_reg)
      fwd_b = 2'b01;
  end

  always_comb begin
    case (fwd_a)
      2'b10:   ex_a = exmem_alu_reg;
      2'b01:   ex_a = wb_data;
      default: ex_a = idex_rd1_reg;
    endcase
    case (fwd_b)
      2'b10:   ex_rs2 = exmem_alu_reg;
      2'b01:   ex_rs2 = wb_data;
      default: ex_rs2 = idex_rd2_reg;
    endcase
  end

  assign ex_b = idex_ctrl_reg.alusrc ? idex_imm_reg : ex_rs2;

  always_comb begin
    ex_result = '0;
    case (idex_ctrl_reg.aluop)
      2'b00: ex_result = ex_a + ex_b;
      2'b01: ex_result = ex_a - ex_b;
      2'b10: begin
        case (idex_funct4_reg)
          4'b0000: ex_result = ex_a + ex_b;
          4'b1000: ex_result = ex_a - ex_b;
          4'b0111: ex_result = ex_a & ex_b;
          4'b0110: ex_result = ex_a | ex_b;
          default: ex_result = '0;
        endcase
      end
      default: ex_result = '0;
    endcase
  end

  assign ex_zero   = (ex_result == 64'd0);
  assign ex_blt    = $signed(ex_a) < $signed(ex_rs2);
  assign ex_target = idex_pc_reg + (idex_imm_reg << 1);

  // ---------------- MEM ----------------
  assign mem_addr = exmem_alu_reg[5:0];
  assign taken    = exmem_branch_reg &
                    (((exmem_funct3_reg == 3'b000) & exmem_zero_reg) |
                     ((exmem_funct3_reg == 3'b100) & exmem_blt_reg));

  generate
    for (gi = 0; gi < 8; gi++) begin : g_dmem_rd
      assign mem_rdata[gi*8 +: 8] = dmem_reg[mem_addr + 6'(gi)];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem_reg[i] <= '0;
    end else if (exmem_memwrite_reg) begin
      for (int i = 0; i < 8; i++) dmem_reg[mem_addr + 6'(i)] <= exmem_store_reg[i*8 +: 8];
    end
  end

  // ---------------- WB ----------------
  assign wb_data = memwb_memtoreg_reg ? memwb_rdata_reg : memwb_alu_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (memwb_regwrite_reg && memwb_rd_reg != 5'd0) begin
      rf_reg[memwb_rd_reg] <= wb_data;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg             <= '0;
      ifid_inst_reg      <= '0;
      ifid_pc_reg        <= '0;
      idex_ctrl_reg      <= '0;
      idex_pc_reg        <= '0;
      idex_rd1_reg       <= '0;
      idex_rd2_reg       <= '0;
      idex_imm_reg       <= '0;
      idex_rs1_reg       <= '0;
      idex_rs2_reg       <= '0;
      idex_rd_reg        <= '0;
      idex_funct4_reg    <= '0;
      exmem_branch_reg   <= 1'b0;
      exmem_memtoreg_reg <= 1'b0;
      exmem_memwrite_reg <= 1'b0;
      exmem_regwrite_reg <= 1'b0;
      exmem_zero_reg     <= 1'b0;
      exmem_blt_reg      <= 1'b0;
      exmem_funct3_reg   <= '0;
      exmem_rd_reg       <= '0;
      exmem_alu_reg      <= '0;
      exmem_store_reg    <= '0;
      exmem_target_reg   <= '0;
      memwb_regwrite_reg <= 1'b0;
      memwb_memtoreg_reg <= 1'b0;
      memwb_rd_reg       <= '0;
      memwb_alu_reg      <= '0;
      memwb_rdata_reg    <= '0;
    end else begin
      pc_reg <= pc_next;

      if (taken) begin
        ifid_inst_reg <= '0;
        ifid_pc_reg   <= '0;
      end else if (!bus.stall) begin
        ifid_inst_reg <= fetch_word;
        ifid_pc_reg   <= pc_reg;
      end

      // Flush and stall both turn ID/EX into an all-zero bubble.
      if (taken || bus.stall) begin
        idex_ctrl_reg   <= '0;
        idex_pc_reg     <= '0;
        idex_rd1_reg    <= '0;
        idex_rd2_reg    <= '0;
        idex_imm_reg    <= '0;
        idex_rs1_reg    <= '0;
        idex_rs2_reg    <= '0;
        idex_rd_reg     <= '0;
        idex_funct4_reg <= '0;
      end else begin
        idex_ctrl_reg   <= id_ctrl;
        idex_pc_reg     <= ifid_pc_reg;
        idex_rd1_reg    <= id_rd1;
        idex_rd2_reg    <= id_rd2;
        idex_imm_reg    <= id_imm;
        idex_rs1_reg    <= id_rs1;
        idex_rs2_reg    <= id_rs2;
        idex_rd_reg     <= id_rd;
        idex_funct4_reg <= id_funct4;
      end

      if (taken) begin
        exmem_branch_reg   <= 1'b0;
        exmem_memtoreg_reg <= 1'b0;
        exmem_memwrite_reg <= 1'b0;
        exmem_regwrite_reg <= 1'b0;
        exmem_zero_reg     <= 1'b0;
        exmem_blt_reg      <= 1'b0;
        exmem_funct3_reg   <= '0;
        exmem_rd_reg       <= '0;
        exmem_alu_reg      <= '0;
        exmem_store_reg    <= '0;
        exmem_target_reg   <= '0;
      end else begin
        exmem_branch_reg   <= idex_ctrl_reg.branch;
        exmem_memtoreg_reg <= idex_ctrl_reg.memtoreg;
        exmem_memwrite_reg <= idex_ctrl_reg.memwrite;
        exmem_regwrite_reg <= idex_ctrl_reg.regwrite;
        exmem_zero_reg     <= ex_zero;
        exmem_blt_reg      <= ex_blt;
        exmem_funct3_reg   <= idex_funct4_reg[2:0];
        exmem_rd_reg       <= idex_rd_reg;
        exmem_alu_reg      <= ex_result;
        exmem_store_reg    <= ex_rs2;
        exmem_target_reg   <= ex_target;
      end

      memwb_regwrite_reg <= exmem_regwrite_reg;
      memwb_memtoreg_reg <= exmem_memtoreg_reg;
      memwb_rd_reg       <= exmem_rd_reg;
      memwb_alu_reg      <= exmem_alu_reg;
      memwb_rdata_reg    <= mem_rdata;
    end
  end

  // ---------------- observation outputs ----------------
  assign bus.branch   = id_ctrl.branch;
  assign bus.memread  = id_ctrl.memread;
  assign bus.memtoreg = id_ctrl.memtoreg;
  assign bus.memwrite = id_ctrl.memwrite;
  assign bus.regwrite = id_ctrl.regwrite;
  assign bus.ALUsrc   = id_ctrl.alusrc;
  assign bus.ALUop    = id_ctrl.aluop;

  assign bus.Branch   = idex_ctrl_reg.branch;
  assign bus.Memread  = idex_ctrl_reg.memread;
  assign bus.Memtoreg = idex_ctrl_reg.memtoreg;
  assign bus.Memwrite = idex_ctrl_reg.memwrite;
  assign bus.Regwrite = idex_ctrl_reg.regwrite;
  assign bus.Alusrc   = idex_ctrl_reg.alusrc;
  assign bus.aluop    = idex_ctrl_reg.aluop;

  assign bus.pc_out        = pc_reg;
  assign bus.pc_in         = pc_next;
  assign bus.adderout1     = pc_plus4;
  assign bus.adderout2     = ex_target;
  assign bus.instruction   = fetch_word;
  assign bus.inst_ifid_out = ifid_inst_reg;

  assign bus.opcode    = id_opcode;
  assign bus.rd        = id_rd;
  assign bus.rs1       = id_rs1;
  assign bus.rs2       = id_rs2;
  assign bus.funct3    = id_funct3;
  assign bus.funct7    = id_funct7;
  assign bus.imm_data  = id_imm;
  assign bus.readdata1 = id_rd1;
  assign bus.readdata2 = id_rd2;

  assign bus.RS1        = idex_rs1_reg;
  assign bus.RS2        = idex_rs2_reg;
  assign bus.RD         = idex_rd_reg;
  assign bus.funct4_out = idex_funct4_reg;
  assign bus.forwardA   = fwd_a;
  assign bus.forwardB   = fwd_b;

  assign bus.a1         = ex_a;
  assign bus.M1         = ex_rs2;
  assign bus.M2         = ex_b;
  assign bus.random     = ex_result;
  assign bus.d          = mem_rdata;
  assign bus.write_data = wb_data;
  assign bus.BLT_Flag   = ex_blt;
  assign bus.regwrite_memwb_out = memwb_regwrite_reg;

  assign bus.r8  = rf_reg[8];
  assign bus.r19 = rf_reg[19];
  assign bus.r20 = rf_reg[20];
  assign bus.r21 = rf_reg[21];
  assign bus.r22 = rf_reg[22];

endmodule

// File: tb/tb_riscv_task3.sv
// Directed bench for riscv_task3: walks the built-in program edge by edge and
// compares hand-derived pipeline values, then repeats with a mid-program stall.
module tb_riscv_task3;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  riscv_task3_if bus ();
  riscv_task3 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.stall = 1'b0;
    tick(2);
    vectors++; if (bus.pc_out !== 64'd0) begin errors++; $display("FAIL rst_pc: got %h exp %h", bus.pc_out, 64'd0); end
    vectors++; if (bus.inst_ifid_out !== 32'd0) begin errors++; $display("FAIL rst_ifid: got %h exp %h", bus.inst_ifid_out, 32'd0); end
    vectors++; if (bus.r19 !== 64'd0) begin errors++; $display("FAIL rst_r19: got %h exp %h", bus.r19, 64'd0); end
    vectors++; if (bus.Regwrite !== 1'b0) begin errors++; $display("FAIL rst_idex_rw: got %b exp 0", bus.Regwrite); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (bus.pc_out !== 64'd0) begin errors++; $display("FAIL rel_pc: got %h exp %h", bus.pc_out, 64'd0); end
    tick(1);
    $display("E1: pc=%h ifid=%h", bus.pc_out, bus.inst_ifid_out);
    vectors++; if (bus.pc_out !== 64'd4) begin errors++; $display("FAIL e1_pc: got %h exp %h", bus.pc_out, 64'd4); end
    vectors++; if (bus.adderout1 !== 64'd8) begin errors++; $display("FAIL e1_add1: got %h exp %h", bus.adderout1, 64'd8); end
    vectors++; if (bus.inst_ifid_out !== 32'h00500993) begin errors++; $display("FAIL e1_ifid: got %h exp %h", bus.inst_ifid_out, 32'h00500993); end
    vectors++; if (bus.opcode !== 7'h13) begin errors++; $display("FAIL e1_opcode: got %h exp %h", bus.opcode, 7'h13); end
    vectors++; if (bus.rd !== 5'd19) begin errors++; $display("FAIL e1_rd: got %0d exp 19", bus.rd); end
    vectors++; if ({bus.regwrite, bus.ALUsrc, bus.memread, bus.memwrite, bus.branch, bus.ALUop} !== 7'b1100010) begin errors++; $display("FAIL e1_ctrl: got %b exp %b", {bus.regwrite, bus.ALUsrc, bus.memread, bus.memwrite, bus.branch, bus.ALUop}, 7'b1100010); end
    vectors++; if (bus.imm_data !== 64'd5) begin errors++; $display("FAIL e1_imm: got %h exp %h", bus.imm_data, 64'd5); end
    tick(1);
    vectors++; if (bus.pc_out !== 64'd8) begin errors++; $display("FAIL e2_pc: got %h exp %h", bus.pc_out, 64'd8); end
    tick(1);
    $display("E3: pc=%h ifid=%h", bus.pc_out, bus.inst_ifid_out);
    vectors++; if (bus.pc_out !== 64'd12) begin errors++; $display("FAIL e3_pc: got %h exp %h", bus.pc_out, 64'd12); end
    vectors++; if (bus.adderout1 !== 64'd16) begin errors++; $display("FAIL e3_add1: got %h exp %h", bus.adderout1, 64'd16); end
    vectors++; if ({bus.rs1, bus.rs2} !== {5'd19, 5'd20}) begin errors++; $display("FAIL e3_rs: got %0d,%0d exp 19,20", bus.rs1, bus.rs2); end
    vectors++; if (bus.ALUsrc !== 1'b0) begin errors++; $display("FAIL e3_alusrc: got %b exp 0", bus.ALUsrc); end
  endtask

  task automatic test_forward_add;
    tick(1);
    $display("E4 add: fA=%b fB=%b a1=%0d M2=%0d res=%0d", bus.forwardA, bus.forwardB, bus.a1, bus.M2, bus.random);
    vectors++; if (bus.forwardA !== 2'b01) begin errors++; $display("FAIL add_fwdA: got %b exp 01", bus.forwardA); end
    vectors++; if (bus.forwardB !== 2'b10) begin errors++; $display("FAIL add_fwdB: got %b exp 10", bus.forwardB); end
    vectors++; if (bus.a1 !== 64'd5) begin errors++; $display("FAIL add_a1: got %h exp %h", bus.a1, 64'd5); end
    vectors++; if (bus.M2 !== 64'd3) begin errors++; $display("FAIL add_M2: got %h exp %h", bus.M2, 64'd3); end
    vectors++; if (bus.random !== 64'd8) begin errors++; $display("FAIL add_res: got %h exp %h", bus.random, 64'd8); end
    vectors++; if (bus.RD !== 5'd21) begin errors++; $display("FAIL add_RD: got %0d exp 21", bus.RD); end
  endtask

  task automatic test_sub;
    tick(1);
    $display("E5 sub: fA=%b fB=%b a1=%0d M1=%0d res=%0d", bus.forwardA, bus.forwardB, bus.a1, bus.M1, bus.random);
    vectors++; if (bus.forwardA !== 2'b10) begin errors++; $display("FAIL sub_fwdA: got %b exp 10", bus.forwardA); end
    vectors++; if (bus.forwardB !== 2'b00) begin errors++; $display("FAIL sub_fwdB: got %b exp 00", bus.forwardB); end
    vectors++; if (bus.a1 !== 64'd8) begin errors++; $display("FAIL sub_a1: got %h exp %h", bus.a1, 64'd8); end
    vectors++; if (bus.M1 !== 64'd5) begin errors++; $display("FAIL sub_M1: got %h exp %h", bus.M1, 64'd5); end
    vectors++; if (bus.random !== 64'd3) begin errors++; $display("FAIL sub_res: got %h exp %h", bus.random, 64'd3); end
    vectors++; if (bus.funct4_out !== 4'b1000) begin errors++; $display("FAIL sub_f4: got %b exp 1000", bus.funct4_out); end
  endtask

  task automatic test_store_load;
    tick(1);
    $display("E6 sd: fB=%b M1=%0d addr=%0d", bus.forwardB, bus.M1, bus.random);
    vectors++; if (bus.Memwrite !== 1'b1) begin errors++; $display("FAIL sd_memwrite: got %b exp 1", bus.Memwrite); end
    vectors++; if (bus.forwardB !== 2'b10) begin errors++; $display("FAIL sd_fwdB: got %b exp 10", bus.forwardB); end
    vectors++; if (bus.M1 !== 64'd3) begin errors++; $display("FAIL sd_data: got %h exp %h", bus.M1, 64'd3); end
    vectors++; if (bus.random !== 64'd0) begin errors++; $display("FAIL sd_addr: got %h exp %h", bus.random, 64'd0); end
    vectors++; if ({bus.regwrite_memwb_out, bus.write_data} !== {1'b1, 64'd8}) begin errors++; $display("FAIL wb_add: got %b/%h exp 1/%h", bus.regwrite_memwb_out, bus.write_data, 64'd8); end
    tick(1);
    $display("E7: r21=%0d", bus.r21);
    vectors++; if (bus.r21 !== 64'd8) begin errors++; $display("FAIL r21: got %h exp %h", bus.r21, 64'd8); end
    vectors++; if (bus.Memread !== 1'b1) begin errors++; $display("FAIL ld_memread: got %b exp 1", bus.Memread); end
    tick(1);
    $display("E8: r22=%0d d=%0d", bus.r22, bus.d);
    vectors++; if (bus.r22 !== 64'd3) begin errors++; $display("FAIL r22: got %h exp %h", bus.r22, 64'd3); end
    vectors++; if (bus.d !== 64'd3) begin errors++; $display("FAIL dmem0: got %h exp %h", bus.d, 64'd3); end
  endtask

  task automatic test_branch;
    $display("E8 blt: flag=%b target=%h res=%h", bus.BLT_Flag, bus.adderout2, bus.random);
    vectors++; if (bus.BLT_Flag !== 1'b1) begin errors++; $display("FAIL blt_flag: got %b exp 1", bus.BLT_Flag); end
    vectors++; if (bus.adderout2 !== 64'h20) begin errors++; $display("FAIL blt_target: got %h exp %h", bus.adderout2, 64'h20); end
    vectors++; if (bus.random !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL blt_sub: got %h exp %h", bus.random, 64'hFFFF_FFFF_FFFF_FFFE); end
    tick(1);
    $display("E9: pc=%h pc_in=%h", bus.pc_out, bus.pc_in);
    vectors++; if (bus.pc_out !== 64'h24) begin errors++; $display("FAIL e9_pc: got %h exp %h", bus.pc_out, 64'h24); end
    vectors++; if (bus.pc_in !== 64'h20) begin errors++; $display("FAIL e9_pc_in: got %h exp %h", bus.pc_in, 64'h20); end
    tick(1);
    $display("E10: pc=%h ifid=%h r8=%0d", bus.pc_out, bus.inst_ifid_out, bus.r8);
    vectors++; if (bus.pc_out !== 64'h20) begin errors++; $display("FAIL e10_pc: got %h exp %h", bus.pc_out, 64'h20); end
    vectors++; if (bus.inst_ifid_out !== 32'd0) begin errors++; $display("FAIL e10_flush_ifid: got %h exp %h", bus.inst_ifid_out, 32'd0); end
    vectors++; if ({bus.Regwrite, bus.aluop} !== 3'b000) begin errors++; $display("FAIL e10_flush_idex: got %b exp 000", {bus.Regwrite, bus.aluop}); end
    vectors++; if (bus.r8 !== 64'd3) begin errors++; $display("FAIL ld_r8: got %h exp %h", bus.r8, 64'd3); end
    tick(1);
    vectors++; if (bus.inst_ifid_out !== 32'h00000063) begin errors++; $display("FAIL e11_ifid: got %h exp %h", bus.inst_ifid_out, 32'h00000063); end
  endtask

  task automatic test_loop;
    tick(3);
    $display("E14: pc=%h", bus.pc_out);
    vectors++; if (bus.pc_out !== 64'h20) begin errors++; $display("FAIL loop1_pc: got %h exp %h", bus.pc_out, 64'h20); end
    tick(4);
    $display("E18: pc=%h r8=%0d", bus.pc_out, bus.r8);
    vectors++; if (bus.pc_out !== 64'h20) begin errors++; $display("FAIL loop2_pc: got %h exp %h", bus.pc_out, 64'h20); end
    vectors++; if (bus.r8 !== 64'd3) begin errors++; $display("FAIL loop_r8: got %h exp %h", bus.r8, 64'd3); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("mid reset: pc=%h r21=%0d r8=%0d", bus.pc_out, bus.r21, bus.r8);
    vectors++; if (bus.pc_out !== 64'd0) begin errors++; $display("FAIL rst2_pc: got %h exp %h", bus.pc_out, 64'd0); end
    vectors++; if ({bus.r21, bus.r8} !== 128'd0) begin errors++; $display("FAIL rst2_regs: got %h/%h exp 0/0", bus.r21, bus.r8); end
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    vectors++; if (bus.pc_out !== 64'd12) begin errors++; $display("FAIL rst2_e3_pc: got %h exp %h", bus.pc_out, 64'd12); end
    @(negedge clk);
    bus.stall = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      tick(1);
      $display("stall %0d: pc=%h ifid=%h", s, bus.pc_out, bus.inst_ifid_out);
      vectors++; if (bus.pc_out !== 64'd12) begin errors++; $display("FAIL stall%0d_pc: got %h exp %h", s, bus.pc_out, 64'd12); end
      vectors++; if (bus.inst_ifid_out !== 32'h01498AB3) begin errors++; $display("FAIL stall%0d_ifid: got %h exp %h", s, bus.inst_ifid_out, 32'h01498AB3); end
      vectors++; if (bus.Regwrite !== 1'b0) begin errors++; $display("FAIL stall%0d_bubble: got %b exp 0", s, bus.Regwrite); end
    end
    @(negedge clk);
    bus.stall = 1'b0;
    tick(25);
    $display("after stall: r19=%0d r20=%0d r21=%0d r22=%0d r8=%0d", bus.r19, bus.r20, bus.r21, bus.r22, bus.r8);
    vectors++; if (bus.r19 !== 64'd5) begin errors++; $display("FAIL fin_r19: got %h exp %h", bus.r19, 64'd5); end
    vectors++; if (bus.r20 !== 64'd3) begin errors++; $display("FAIL fin_r20: got %h exp %h", bus.r20, 64'd3); end
    vectors++; if (bus.r21 !== 64'd8) begin errors++; $display("FAIL fin_r21: got %h exp %h", bus.r21, 64'd8); end
    vectors++; if (bus.r22 !== 64'd3) begin errors++; $display("FAIL fin_r22: got %h exp %h", bus.r22, 64'd3); end
    vectors++; if (bus.r8 !== 64'd3) begin errors++; $display("FAIL fin_r8: got %h exp %h", bus.r8, 64'd3); end
  endtask

  initial begin
    test_reset();
    test_forward_add();
    test_sub();
    test_store_load();
    test_branch();
    test_loop();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/riscv_task3.md
RISCV_TASK3 -- requirements
Module: riscv_task3

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` (input, 1) and `reset` (input, 1).
REQ-002 The block SHALL have input `stall` (1 bit): hazard stall request.
REQ-003 The block SHALL have the following ID-stage control outputs (1 bit each): `branch`, `memread`, `memtoreg`, `memwrite`, `regwrite`, `ALUsrc`.
REQ-004 The block SHALL have output `ALUop` (2 bits): ID-stage ALU operation class.
REQ-005 The block SHALL have outputs `Branch`, `Memread`, `Memtoreg`, `Memwrite`, `Regwrite`, `Alusrc` (1 bit each) and `aluop` (2 bits): the same controls, as held in the ID/EX register.
REQ-006 The block SHALL have the following 64-bit outputs:
- `pc_out`: current PC.
- `pc_in`: next PC.
- `adderout1`: pc_out+4.
- `adderout2`: branch target, ID/EX PC + (imm<<1).
REQ-007 The block SHALL have 32-bit outputs `instruction` (fetched word) and `inst_ifid_out` (IF/ID instruction).
REQ-008 The block SHALL have decode-field outputs of `inst_ifid_out`: `opcode` (7 bits), `rd`, `rs1`, `rs2` (5 bits each), `funct3` (3 bits), `funct7` (7 bits).
REQ-009 The block SHALL have 64-bit outputs `imm_data` (immediate-generator output) and `readdata1`, `readdata2` (register-file reads).
REQ-010 The block SHALL have outputs `RS1`, `RS2`, `RD` (5 bits each) and `funct4_out` (4 bits, {funct7[5], funct3}), all from the ID/EX register.
REQ-011 The block SHALL have outputs `forwardA`, `forwardB` (2 bits each), encoded 00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB.
REQ-012 The block SHALL have the following 64-bit datapath outputs:
- `a1`: forwarded ALU operand A.
- `M1`: forwarded rs2, also the store data.
- `M2`: ALU operand B after the ALUsrc mux.
- `random`: EX-stage ALU result.
- `d`: data-memory read data.
- `write_data`: WB write-back value.
REQ-013 The block SHALL have outputs `BLT_Flag` (1 bit, EX signed a1<M1) and `regwrite_memwb_out` (1 bit, MEM/WB regwrite).
REQ-014 The block SHALL have outputs `r8`, `r19`, `r20`, `r21`, `r22` (64 bits each): live contents of those registers.

Function
REQ-015 The block SHALL be a 5-stage RV64I pipeline (IF/ID/EX/MEM/WB) with IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-016 The block SHALL support add, sub, and, or, addi, ld, sd, beq and blt; any other opcode SHALL decode to all-zero controls (NOP).
REQ-017 Control SHALL be:
- R-type: regwrite, ALUop=10.
- addi: regwrite, ALUsrc, ALUop=10, funct7[5] treated as 0.
- ld: memread, memtoreg, regwrite, ALUsrc, ALUop=00.
- sd: memwrite, ALUsrc, ALUop=00.
- beq/blt: branch, ALUop=01.
REQ-018 The ALU SHALL perform: ALUop 00 → add; 01 → subtract; 10 → funct4 0000 add, 1000 sub, 0111 and, 0110 or; result 64 bits, wrap-around, no overflow trap.
REQ-019 The immediate generator SHALL sign-extend I-, S- and B-type immediates (B-type without the implicit zero LSB) to 64 bits.
REQ-020 Forwarding SHALL be:
- EX/MEM takes priority when EX/MEM.regwrite, rd≠0 and rd matches the source.
- Otherwise MEM/WB is used when MEM/WB.regwrite, rd≠0 and rd matches.
- Otherwise ID/EX.
REQ-021 The register file SHALL be 32×64 with x0 hardwired to 0, written on the clock edge, and SHALL bypass a same-cycle WB write to ID reads.
REQ-022 Branch resolution in MEM SHALL be: taken = EX/MEM.branch AND ((funct3=000 AND zero) OR (funct3=100 AND registered BLT_Flag)).
REQ-023 On a taken branch, pc_in SHALL be the registered adderout2, and IF/ID, ID/EX and EX/MEM SHALL be flushed to NOP on the next edge.
REQ-024 While stall=1, the PC and IF/ID SHALL hold and ID/EX SHALL load a bubble; a taken branch SHALL override stall.
REQ-025 Instruction memory SHALL be a byte-addressed little-endian ROM of at least 64 bytes; addresses beyond the program SHALL read 0 (NOP).
REQ-026 Data memory SHALL be 64 bytes, zero-initialised, with doubleword little-endian accesses, synchronous write and combinational read.
REQ-027 The default program SHALL be:
- 0x00 addi x19,x0,5
- 0x04 addi x20,x0,3
- 0x08 add x21,x19,x20
- 0x0C sub x22,x21,x19
- 0x10 sd x22,0(x0)
- 0x14 ld x8,0(x0)
- 0x18 blt x20,x19,+8
- 0x1C addi x8,x0,99
- 0x20 beq x0,x0,0 (self-loop)

Reset
REQ-028 While reset=0, all of the following SHALL clear to 0, asynchronously: PC, all pipeline registers, the register file, data memory and all derived outputs.
REQ-029 While reset=0, fetch SHALL not advance; the first fetch at PC 0 SHALL occur on the first clk rising edge after reset rises.
REQ-030 Reassertion of reset mid-program SHALL restart execution from PC 0 with cleared state.

Verification
REQ-031 The bench SHALL cover reset low then released: pc_out=0 during reset, then 4, 8, 12 on successive edges, with adderout1 = pc_out+4.
REQ-032 The bench SHALL cover the EX/MEM forward: when add x21 executes, forwardA=01 and forwardB=10, and after write-back r21=8.
REQ-033 The bench SHALL cover sub x22: forwardA=10, and r22=3 after write-back.
REQ-034 The bench SHALL cover sd/ld: data memory [0]=3 after the store, and r8=3 after the load.
REQ-035 The bench SHALL cover the taken blt: BLT_Flag=1 in EX, the addi at 0x1C is flushed, r8 stays 3, and pc_out then cycles at 0x20.
REQ-036 The bench SHALL cover stall=1 held for 3 cycles mid-program: pc_out and inst_ifid_out are unchanged, and the final r19=5, r20=3, r21=8, r22=3, r8=3.
